div_seq_unit: RTL and testbench

- Multi-cycle signed integer divider on the ALU's DIV path (operation code 5'b01111).
- Receives the Y-register operand (dividend) and the bus operand (divisor).
- Produces a 2*WIDTH result for the Z register: ZHigh takes the remainder and forwards to HI; ZLow takes the quotient and forwards to LO.
- Replaces single-cycle division so the control sequencer can stall on busy/done instead of assuming a one-step T4.

---
 rtl/div_seq_unit_if.sv | 23 ++
 rtl/div_seq_unit.sv | 118 +++++++++++
 tb/tb_div_seq_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/div_seq_unit_if.sv
// Handshake and operand/result bundle between the control sequencer and the
// sequential divider.
interface div_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic                 i_start;
  logic [WIDTH-1:0]     i_dividend;
  logic [WIDTH-1:0]     i_divisor;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_div_by_zero;
  logic [2*WIDTH-1:0]   o_result;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_busy, o_done, o_div_by_zero, o_result
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_busy, o_done, o_div_by_zero, o_result
  );
endinterface

// File: rtl/div_seq_unit.sv
// Multi-cycle signed restoring divider: one quotient bit per cycle, then a
// sign-fix cycle. Result is {remainder, quotient}.
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic          i_clock,
  input  logic          i_clear,
  div_seq_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [WIDTH:0]      r_rem;
  logic [WIDTH-1:0]    r_quo;
  logic [WIDTH-1:0]    r_dvsr;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_busy;
  logic                r_done;
  logic                r_dz;
  logic [2*WIDTH-1:0]  r_result;

  logic                w_dvd_neg;
  logic                w_dvs_neg;
  logic [WIDTH-1:0]    w_dvd_mag;
  logic [WIDTH-1:0]    w_dvs_mag;
  logic [WIDTH+1:0]    w_trial;
  logic [WIDTH-1:0]    w_quo_fix;
  logic [WIDTH-1:0]    w_rem_fix;

  assign w_dvd_neg = bus.i_dividend[WIDTH-1];
  assign w_dvs_neg = bus.i_divisor[WIDTH-1];
  // Unsigned magnitudes so the most-negative operand (2^(WIDTH-1)) still fits.
  assign w_dvd_mag = w_dvd_neg ? (~bus.i_dividend + 1'b1) : bus.i_dividend;
  assign w_dvs_mag = w_dvs_neg ? (~bus.i_divisor + 1'b1) : bus.i_divisor;

  // Shifted remainder minus divisor; the top bit is the borrow.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {2'b00, r_dvsr};

  assign w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_quo   <= w_dvd_mag;
            r_dvsr  <= w_dvs_mag;
            r_rem   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_dz    <= 1'b0;
            r_state <= (bus.i_divisor == '0) ? S_FIX : S_CALC;
          end
        end

        S_CALC: begin
          if (!w_trial[WIDTH+1]) begin
            r_rem <= w_trial[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          // A zero divisor magnitude means the divide-by-zero path: r_quo still
          // holds |dividend|, which the remainder sign fix restores.
          if (r_dvsr == '0) begin
            r_result <= {(r_neg_r ? (~r_quo + 1'b1) : r_quo), {WIDTH{1'b1}}};
            r_dz     <= 1'b1;
          end else begin
            r_result <= {w_rem_fix, w_quo_fix};
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_div_by_zero = r_dz;
  assign bus.o_result      = r_result;
endmodule

// File: tb/tb_div_seq_unit.sv
// Randomized and directed bench for div_seq_unit against a plain-arithmetic
// signed division model.
module tb_div_seq_unit;
  localparam int WIDTH = 32;

  logic clk;
  logic clear;
  int   n_cmp;
  int   n_bad;

  div_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  div_seq_unit #(.WIDTH(WIDTH)) dut (
    .i_clock (clk),
    .i_clear (clear),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: native 64-bit signed division truncates toward zero and the
  // remainder follows the dividend, which is exactly the required rounding.
  task automatic model(input logic [31:0] dvd, input logic [31:0] dvs,
                       output logic [63:0] res, output logic dz);
    longint a, b, q, r;
    logic [63:0] qv, rv;
    a = longint'($signed(dvd));
    b = longint'($signed(dvs));
    if (b == 0) begin
      dz  = 1'b1;
      res = {dvd, 32'hFFFF_FFFF};
    end else begin
      dz  = 1'b0;
      q   = a / b;
      r   = a % b;
      qv  = q;
      rv  = r;
      res = {rv[31:0], qv[31:0]};
    end
  endtask

  // Entered and left at a negedge. inj_at/clr_at name the cycle after the
  // start edge at which a stray start or a clear is applied (0 = never).
  task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs,
                        input int inj_at, input int clr_at);
    logic [63:0] exp_res;
    logic        exp_dz;
    int          lat;
    int          busy_low;
    model(dvd, dvs, exp_res, exp_dz);
    lat      = 0;
    busy_low = 0;
    bus.i_start    = 1'b1;
    bus.i_dividend = dvd;
    bus.i_divisor  = dvs;
    @(posedge clk);
    @(negedge clk);
    bus.i_start    = 1'b0;
    bus.i_dividend = $urandom;
    bus.i_divisor  = $urandom;
    check("busy_after_accept", {63'd0, bus.o_busy}, 64'd1);
    check("dz_cleared_on_accept", {63'd0, bus.o_div_by_zero}, 64'd0);
    for (int k = 1; k <= 64; k++) begin
      if (k == inj_at) begin
        bus.i_start    = 1'b1;
        bus.i_dividend = 32'd50;
        bus.i_divisor  = 32'd5;
      end
      if (k == clr_at) clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b0;
      clear       = 1'b0;
      if (k == clr_at) begin
        check("clear_busy", {63'd0, bus.o_busy}, 64'd0);
        check("clear_done", {63'd0, bus.o_done}, 64'd0);
        check("clear_result", bus.o_result, 64'd0);
        return;
      end
      if (bus.o_done) begin
        lat = k;
        break;
      end
      if (!bus.o_busy) busy_low++;
    end
    check("latency", lat, exp_dz ? 64'd1 : 64'd33);
    check("busy_low_while_running", busy_low, 64'd0);
    check("busy_at_done", {63'd0, bus.o_busy}, 64'd0);
    check("result", bus.o_result, exp_res);
    check("div_by_zero", {63'd0, bus.o_div_by_zero}, {63'd0, exp_dz});
  endtask

  initial begin
    int stray;
    logic [31:0] rd, rs;
    n_cmp = 0;
    n_bad = 0;
    clear = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    check("reset_busy", {63'd0, bus.o_busy}, 64'd0);
    check("reset_done", {63'd0, bus.o_done}, 64'd0);
    check("reset_dz", {63'd0, bus.o_div_by_zero}, 64'd0);
    check("reset_result", bus.o_result, 64'd0);

    // Directed cases, back to back so each start lands on the done cycle.
    run_op(32'd100, 32'd7, 0, 0);
    check("plan_100_7", bus.o_result, 64'h00000002_0000000E);
    run_op(32'hFFFF_FF9C, 32'd7, 0, 0);
    check("plan_m100_7", bus.o_result, 64'hFFFFFFFE_FFFFFFF2);
    run_op(32'h22, 32'h24, 0, 0);
    check("plan_22_24", bus.o_result, 64'h00000022_00000000);
    run_op(32'h28, 32'd0, 0, 0);
    check("plan_div0", bus.o_result, 64'h00000028_FFFFFFFF);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("plan_overflow", bus.o_result, 64'h00000000_80000000);
    run_op(32'h8000_0000, 32'd0, 0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(32'd7, 32'hFFFF_FFF9, 0, 0);

    // Start while busy is dropped and never queued.
    run_op(32'd100, 32'd7, 10, 0);
    check("ignored_start_result", bus.o_result, 64'h00000002_0000000E);
    @(negedge clk);
    check("done_one_cycle", {63'd0, bus.o_done}, 64'd0);
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) stray++;
    end
    check("no_queued_op", stray, 64'd0);

    // Clear mid-operation discards the result and never reports done.
    run_op(32'd100, 32'd7, 0, 15);
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done || bus.o_busy) stray++;
    end
    check("cleared_op_silent", stray, 64'd0);
    run_op(32'd9, 32'hFFFF_FFFE, 0, 0);
    check("plan_9_m2", bus.o_result, 64'h00000001_FFFFFFFC);

    // Random operands, with a mix of small, zero and extreme divisors.
    for (int i = 0; i < 40; i++) begin
      rd = $urandom;
      rs = $urandom;
      case ($urandom_range(0, 7))
        0: rs = 32'd0;
        1: rs = 32'($signed($urandom_range(0, 16)) - 8);
        2: rd = 32'h8000_0000;
        3: rd = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(rd, rs, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
